// File: rtl/boot_img_chk_if.sv
// Boot image checker bus bundle: SRAM write snoop plus CPU register port.
// The master side drives requests; the checker sits on the slave side.
interface boot_img_chk_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  sram_valid;
   logic [ADDR_W-1:0]     sram_addr;
   logic [DATA_W-1:0]     sram_wdata;
   logic [DATA_W/8-1:0]   sram_wstrb;
   logic                  cpu_valid;
   logic [1:0]            cpu_addr;
   logic [DATA_W-1:0]     cpu_wdata;
   logic [DATA_W/8-1:0]   cpu_wstrb;
   logic [DATA_W-1:0]     cpu_rdata;
   logic                  cpu_ready;

   modport master (
      output sram_valid, sram_addr, sram_wdata, sram_wstrb,
      output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
      input  cpu_rdata, cpu_ready
   );

   modport slave (
      input  sram_valid, sram_addr, sram_wdata, sram_wstrb,
      input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
      output cpu_rdata, cpu_ready
   );
endinterface

// File: rtl/boot_img_chk.sv
// Snoops the boot ROM -> SRAM copy, CRC-32s it and compares against the
// trailing CRC word; holds the CPU in reset until the verdict is known.
module boot_img_chk #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int IMG_WORDS    = 1024,
   parameter bit HOLD_ON_FAIL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic boot,
   boot_img_chk_if.slave bus,
   output logic cpu_hold,
   output logic chk_done,
   output logic chk_ok
);
   localparam int CW = $clog2(IMG_WORDS + 1);
   localparam logic [31:0] POLY = 32'hEDB88320;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC   = 3'd1,
      CHECK = 3'd2,
      PASS  = 3'd3,
      FAIL  = 3'd4
   } state_t;

   state_t              state;
   logic [31:0]         crc;
   logic [CW-1:0]       count;
   logic [ADDR_W-1:0]   last_addr;
   logic                seq_err;
   logic [DATA_W-1:0]   exp;

   // Shifting the whole word LSB-first equals feeding bytes 0..3 in order.
   function automatic logic [31:0] crc_word(input logic [31:0] c,
                                            input logic [31:0] d);
      logic [31:0] r;
      r = c ^ d;
      for (int i = 0; i < 32; i++)
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      return r;
   endfunction

   logic              beat;
   logic              rearm;
   logic              seq_ok;
   logic              last_word;
   logic [31:0]       crc_nxt;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rd_mux;
   logic              unused_bits;

   assign beat      = bus.sram_valid & boot;
   assign rearm     = bus.cpu_valid & (|bus.cpu_wstrb)
                    & (bus.cpu_addr == 2'd0) & bus.cpu_wdata[0];
   assign seq_ok    = (bus.sram_addr == last_addr + ADDR_W'(4))
                    & (&bus.sram_wstrb);
   assign last_word = (count == CW'(IMG_WORDS - 1));
   assign crc_nxt   = crc_word(crc, bus.sram_wdata);
   assign status    = DATA_W'({state, 1'b0, seq_err, chk_ok, chk_done});
   assign unused_bits = ^bus.cpu_wdata[DATA_W-1:1];

   always_comb begin
      rd_mux = '0;
      case (bus.cpu_addr)
         2'd0: rd_mux = status;
         2'd1: rd_mux = ~crc;
         2'd2: rd_mux = DATA_W'(count);
         2'd3: rd_mux = exp;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         crc           <= '1;
         count         <= '0;
         last_addr     <= '0;
         seq_err       <= 1'b0;
         exp           <= '0;
         chk_done      <= 1'b0;
         chk_ok        <= 1'b0;
         cpu_hold      <= 1'b0;
         bus.cpu_ready <= 1'b0;
         bus.cpu_rdata <= '0;
      end else begin
         bus.cpu_ready <= bus.cpu_valid;
         if (bus.cpu_valid && !(|bus.cpu_wstrb))
            bus.cpu_rdata <= rd_mux;
         cpu_hold <= (state == ACC) || (state == CHECK)
                  || ((state == FAIL) && HOLD_ON_FAIL);

         if (rearm) begin
            state    <= IDLE;
            crc      <= '1;
            count    <= '0;
            seq_err  <= 1'b0;
            exp      <= '0;
            chk_done <= 1'b0;
            chk_ok   <= 1'b0;
         end else begin
            case (state)
               IDLE: if (beat) begin
                  crc       <= crc_nxt;
                  count     <= CW'(1);
                  last_addr <= bus.sram_addr;
                  state     <= ACC;
               end
               ACC: begin
                  if (!boot || (bus.sram_valid && !seq_ok)) begin
                     seq_err  <= 1'b1;
                     chk_done <= 1'b1;
                     state    <= FAIL;
                  end else if (bus.sram_valid) begin
                     count <= count + 1'b1;
                     if (last_word) begin
                        exp   <= bus.sram_wdata;
                        state <= CHECK;
                     end else begin
                        crc       <= crc_nxt;
                        last_addr <= bus.sram_addr;
                     end
                  end
               end
               CHECK: begin
                  chk_done <= 1'b1;
                  chk_ok   <= (~crc == exp);
                  state    <= (~crc == exp) ? PASS : FAIL;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_boot_img_chk.sv
// Two checkers (2 words/hold on fail, 4 words/release on fail) driven by
// shared stimulus, scored against a word-list CRC model.
module tb_boot_img_chk;
   localparam logic [31:0] POLY = 32'hEDB88320;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  boot = '0;
   logic        sv = 1'b0;
   logic [31:0] sa = '0, sd = '0;
   logic [3:0]  ss = '0;
   logic        cv = 1'b0;
   logic [1:0]  ca = '0;
   logic [31:0] cd = '0;
   logic [3:0]  cs = '0;
   logic        fc = 1'b0;

   wire [1:0]  hold_o, done_o, ok_o, rdy;
   wire [31:0] rd [2];

   boot_img_chk_if if0 ();
   boot_img_chk_if if1 ();

   assign {if0.sram_valid, if0.sram_addr, if0.sram_wdata, if0.sram_wstrb} = {sv, sa, sd, ss};
   assign {if1.sram_valid, if1.sram_addr, if1.sram_wdata, if1.sram_wstrb} = {sv, sa, sd, ss};
   assign {if0.cpu_valid, if0.cpu_addr, if0.cpu_wdata, if0.cpu_wstrb} = {cv, ca, cd, cs};
   assign {if1.cpu_valid, if1.cpu_addr, if1.cpu_wdata, if1.cpu_wstrb} = {cv, ca, cd, cs};
   assign rdy   = {if1.cpu_ready, if0.cpu_ready};
   assign rd[0] = if0.cpu_rdata;
   assign rd[1] = if1.cpu_rdata;

   boot_img_chk #(.IMG_WORDS(2), .HOLD_ON_FAIL(1'b1)) u0 (
      .clk(clk), .rst(rst), .boot(boot[0]), .bus(if0),
      .cpu_hold(hold_o[0]), .chk_done(done_o[0]), .chk_ok(ok_o[0]));

   boot_img_chk #(.IMG_WORDS(4), .HOLD_ON_FAIL(1'b0)) u1 (
      .clk(clk), .rst(rst), .boot(boot[1]), .bus(if1),
      .cpu_hold(hold_o[1]), .chk_done(done_o[1]), .chk_ok(ok_o[1]));

   // model: phase 0 idle,1 acc,2 check,3 pass,4 fail; image kept as word list
   int          ph [2];
   logic [31:0] img [2][4];
   int          nw [2];
   logic [31:0] ex [2];
   logic [31:0] na [2];
   bit          hx [2], se [2], mh [2];
   logic [32:0] sbq [2][64];
   int          wp [2], rp [2];
   logic [32:0] e_mon;
   int          ncmp = 0, nerr = 0;

   function automatic int nwords(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic logic [31:0] crc_fold(input logic [31:0] c,
                                            input logic [31:0] w);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 4; b++) begin
         r = r ^ {24'h0, w[8*b +: 8]};
         for (int j = 0; j < 8; j++)
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   function automatic logic [31:0] crc_of(input int k);
      logic [31:0] c;
      c = '1;
      for (int i = 0; i < nw[k]; i++) c = crc_fold(c, img[k][i]);
      return ~c;
   endfunction

   function automatic logic [31:0] exp_read(input int k, input logic [1:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         2'd0: begin
            v[6:4] = 3'(ph[k]);
            v[2]   = se[k];
            v[1]   = (ph[k] == 3);
            v[0]   = (ph[k] >= 3);
         end
         2'd1: v = crc_of(k);
         2'd2: v = 32'(nw[k] + (hx[k] ? 1 : 0));
         default: v = ex[k];
      endcase
      return v;
   endfunction

   task automatic chk(input int k, input string nm,
                      input logic [31:0] act, input logic [31:0] expv);
      ncmp++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL u%0d %s: got %h want %h at %0t", k, nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ph[k] = 0; nw[k] = 0; ex[k] = '0; hx[k] = 0;
         se[k] = 0; mh[k] = 0; na[k] = '0; wp[k] = 0; rp[k] = 0;
      end
   endtask

   task automatic model_step();
      bit rearm;
      bit nh;
      rearm = cv && (cs != 0) && (ca == 2'd0) && cd[0];
      for (int k = 0; k < 2; k++) begin
         if (cv) begin
            sbq[k][wp[k]] = {cs == 4'h0, exp_read(k, ca)};
            wp[k] = (wp[k] + 1) % 64;
         end
         nh = (ph[k] == 1) || (ph[k] == 2) || (ph[k] == 4 && k == 0);
         if (rearm) begin
            ph[k] = 0; nw[k] = 0; hx[k] = 0; ex[k] = '0; se[k] = 0;
         end else if (ph[k] == 0) begin
            if (sv && boot[k]) begin
               img[k][0] = sd; nw[k] = 1; na[k] = sa + 32'd4; ph[k] = 1;
            end
         end else if (ph[k] == 1) begin
            if (!boot[k] || (sv && (sa != na[k] || ss != 4'hF))) begin
               se[k] = 1; ph[k] = 4;
            end else if (sv) begin
               if (nw[k] == nwords(k) - 1) begin
                  ex[k] = sd; hx[k] = 1; ph[k] = 2;
               end else begin
                  img[k][nw[k]] = sd; nw[k]++; na[k] = sa + 32'd4;
               end
            end
         end else if (ph[k] == 2) begin
            ph[k] = (crc_of(k) == ex[k]) ? 3 : 4;
         end
         mh[k] = nh;
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk(k, "chk_done", 32'(done_o[k]), 32'(ph[k] >= 3));
         chk(k, "chk_ok", 32'(ok_o[k]), 32'(ph[k] == 3));
         chk(k, "cpu_hold", 32'(hold_o[k]), 32'(mh[k]));
         if (rdy[k]) begin
            chk(k, "ready_has_req", 32'(rp[k] != wp[k]), 32'd1);
            if (rp[k] != wp[k]) begin
               e_mon = sbq[k][rp[k]];
               rp[k] = (rp[k] + 1) % 64;
               if (e_mon[32]) chk(k, "cpu_rdata", rd[k], e_mon[31:0]);
            end
         end
      end
   end

   task automatic tick();
      if (!fc) begin
         cv = ($urandom_range(0, 2) == 0);
         ca = 2'($urandom);
         cd = $urandom;
         cs = 4'h0;
         if ($urandom_range(0, 7) == 0) begin
            cs = 4'($urandom_range(1, 15));
            if (ca == 2'd0) cd[0] = 1'b0;
         end
      end
      @(posedge clk);
      if (rst) model_step();
      #1;
      fc = 1'b0; cv = 1'b0; cs = '0; sv = 1'b0; ss = '0;
   endtask

   task automatic cpu_op(input bit wr, input logic [1:0] a, input logic [31:0] d);
      fc = 1'b1; cv = 1'b1; ca = a; cd = d; cs = wr ? 4'hF : 4'h0;
      tick();
   endtask

   task automatic rearm_all();
      cpu_op(1'b1, 2'd0, 32'd1);
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      sv = 1'b1; sa = a; sd = d; ss = s;
      tick();
   endtask

   task automatic read_all();
      for (int a = 0; a < 4; a++) cpu_op(1'b0, 2'(a), 32'd0);
   endtask

   task automatic run_img(input int k);
      int n, fault, pos;
      logic [31:0] w [4];
      logic [31:0] c, base, a;
      logic [3:0] s;
      n = nwords(k);
      fault = $urandom_range(0, 9);
      pos = $urandom_range(0, n - 1);
      base = $urandom & 32'hFFFF_FFFC;
      c = '1;
      for (int i = 0; i < n - 1; i++) begin
         w[i] = $urandom;
         c = crc_fold(c, w[i]);
      end
      w[n-1] = ~c;
      if ($urandom_range(0, 3) == 0) w[n-1] ^= (32'd1 << $urandom_range(0, 31));
      boot = '0;
      boot[k] = 1'b1;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if (fault == 0 && i == pos && i > 0) begin
            boot[k] = 1'b0;
            tick();
            break;
         end
         a = base + 32'(4 * i);
         s = 4'hF;
         if (fault == 1 && i == pos) a = a + 32'd8;
         if (fault == 2 && i == pos) s = 4'($urandom_range(0, 14));
         beat(a, w[i], s);
      end
      repeat (3) tick();
      read_all();
      boot = '0;
      rearm_all();
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      read_all();

      boot = 2'b01;
      beat(32'hFFFF_F000, 32'h0000_0000, 4'hF);
      beat(32'hFFFF_F004, 32'h2144_DF1C, 4'hF);
      repeat (3) tick();
      read_all();
      beat(32'hFFFF_F008, 32'h1234_5678, 4'hF);
      cpu_op(1'b0, 2'd2, 32'd0);
      rearm_all();
      beat(32'hFFFF_F000, 32'h0000_0000, 4'hF);
      beat(32'hFFFF_F004, 32'h2144_DF1C, 4'hF);
      repeat (3) tick();
      read_all();
      rearm_all();
      beat(32'h0000_0100, 32'hFFFF_FFFF, 4'hF);
      beat(32'h0000_0104, 32'hFFFF_FFFF, 4'hF);
      repeat (3) tick();
      read_all();
      rearm_all();

      boot = 2'b11;
      beat(32'hFFFF_F000, 32'h0000_0000, 4'hF);
      beat(32'hFFFF_F004, 32'h2144_DF1D, 4'hF);
      beat(32'hFFFF_F008, 32'h0000_0000, 4'hF);
      beat(32'hFFFF_F00C, 32'hDEAD_BEEF, 4'hF);
      repeat (3) tick();
      read_all();
      boot = 2'b00;
      rearm_all();

      boot = 2'b10;
      beat(32'h0000_2000, 32'hA5A5_0001, 4'hF);
      beat(32'h0000_2008, 32'hA5A5_0002, 4'hF);
      tick();
      read_all();
      rearm_all();
      beat(32'h0000_2000, 32'hA5A5_0001, 4'hF);
      beat(32'h0000_2004, 32'hA5A5_0002, 4'h7);
      tick();
      read_all();
      rearm_all();

      beat(32'h0000_3000, 32'h1111_1111, 4'hF);
      beat(32'h0000_3004, 32'h2222_2222, 4'hF);
      beat(32'h0000_3008, 32'h3333_3333, 4'hF);
      tick();
      rst = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk(k, "rst_done", 32'(done_o[k]), 32'd0);
         chk(k, "rst_ok", 32'(ok_o[k]), 32'd0);
         chk(k, "rst_hold", 32'(hold_o[k]), 32'd0);
         chk(k, "rst_ready", 32'(rdy[k]), 32'd0);
         chk(k, "rst_rdata", rd[k], 32'd0);
      end
      boot = 2'b00;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      read_all();

      for (int r = 0; r < 40; r++) run_img(r % 2);

      repeat (3) tick();
      for (int k = 0; k < 2; k++)
         chk(k, "sb_drained", 32'(wp[k] - rp[k]), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
